// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for a single-issue RV32I datapath: shared memory port,
// write strobes, retired-instruction counter, debug halt and error traps.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mr,
    input  logic             mw,
    input  logic             rw,
    input  logic             br,
    input  logic             j,
    input  logic             jr,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;
    localparam logic [2:0] S_TRAP    = 3'd6;

    localparam int TMO_W        = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int TMO_LAST_INT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_INT[TMO_W-1:0];

    localparam logic [8:0][6:0] LEGAL_OPS = {
        7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111
    };

    logic [2:0]       state_reg, state_next;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [CNT_W-1:0] instret_reg;
    logic             halted_reg;
    logic             trap_reg;
    logic [1:0]       trap_cause_reg, trap_cause_next;
    logic             commit;
    logic [8:0]       op_hit;
    logic             op_legal;
    logic             req_int;
    logic             stall;
    logic             timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_legal
            assign op_hit[gi] = (opcode == LEGAL_OPS[gi]);
        end
    endgenerate

    assign op_legal = |op_hit;
    assign req_int  = (state_reg == S_FETCH) || (state_reg == S_MEM);
    assign stall    = req_int && !mem_ready;
    // The stall that would make the count reach the limit is the trap cycle;
    // a handshake in that cycle never reaches here because stall is low.
    assign timeout_hit = (MEM_TIMEOUT != 0) && stall && (tmo_cnt_reg == TMO_LAST);

    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        commit          = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        addr_sel        = 1'b0;
        ir_we           = 1'b0;
        rf_we           = 1'b0;
        pc_we           = 1'b0;
        pc_sel          = 2'b00;

        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next      = S_TRAP;
                    trap_cause_next = 2'b10;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    state_next = S_EXECUTE;
                end else begin
                    state_next      = S_TRAP;
                    trap_cause_next = 2'b01;
                end
            end
            S_EXECUTE: begin
                if (mr || mw) begin
                    state_next = S_MEM;
                end else if (br) begin
                    commit = 1'b1;
                    pc_sel = branch_taken ? 2'b01 : 2'b00;
                end else if (j || jr || rw) begin
                    state_next = S_WB;
                end else begin
                    // No flag set: retire as a plain fall-through rather than stall.
                    commit = 1'b1;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = mw;
                if (mem_ready) begin
                    if (mr) begin
                        state_next = S_WB;
                    end else begin
                        commit = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next      = S_TRAP;
                    trap_cause_next = 2'b11;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                commit = 1'b1;
                if (j) begin
                    pc_sel = 2'b10;
                end else if (jr) begin
                    pc_sel = 2'b11;
                end
            end
            S_HALT: begin
                if (!halt_req) begin
                    state_next = S_FETCH;
                end
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (commit) begin
            pc_we      = 1'b1;
            state_next = halt_req ? S_HALT : S_FETCH;
        end

        // Outputs follow rst_n combinationally so a request never outlives reset.
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            ir_we    = 1'b0;
            rf_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_FETCH;
            tmo_cnt_reg    <= '0;
            instret_reg    <= '0;
            halted_reg     <= 1'b0;
            trap_reg       <= 1'b0;
            trap_cause_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            halted_reg     <= (state_next == S_HALT);
            trap_reg       <= (state_next == S_TRAP);
            trap_cause_reg <= trap_cause_next;
            if ((state_next != state_reg) || (req_int && mem_ready)) begin
                tmo_cnt_reg <= '0;
            end else if (stall) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end
            if (commit) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    assign halted     = halted_reg;
    assign trap       = trap_reg;
    assign trap_cause = trap_cause_reg;
    assign instret    = instret_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed-vector bench for multicycle_sequencer with hand-computed cycle-by-cycle expectations.
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mr, mw, rw, br, j, jr;
    logic        branch_taken;
    logic        mem_ready;
    logic        halt_req;
    logic        mem_req, mem_we, addr_sel, ir_we, rf_we, pc_we;
    logic [1:0]  pc_sel;
    logic        halted, trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .mr(mr), .mw(mw), .rw(rw), .br(br), .j(j), .jr(jr),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .halt_req(halt_req),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .halted(halted), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [6:0] op, input logic f_mr, input logic f_mw,
                           input logic f_rw, input logic f_br, input logic f_j, input logic f_jr);
        opcode = op; mr = f_mr; mw = f_mw; rw = f_rw; br = f_br; j = f_j; jr = f_jr;
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
        set_ins(7'd0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_ir_we", 32'(ir_we), 0);
        chk("rst_pc_we", 32'(pc_we), 0);
        chk("rst_instret", instret, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_cause", 32'(trap_cause), 0);
        nxt();
        rst_n = 1'b1;

        // ADD, zero-wait memory
        mem_ready = 1'b1;
        set_ins(OP_R, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("add_c0_ir_we", 32'(ir_we), 1);
        chk("add_c0_mem_req", 32'(mem_req), 1);
        chk("add_c0_addr_sel", 32'(addr_sel), 0);
        nxt(); @(negedge clk);
        chk("add_c1_mem_req", 32'(mem_req), 0);
        chk("add_c1_ir_we", 32'(ir_we), 0);
        nxt(); @(negedge clk);
        chk("add_c2_pc_we", 32'(pc_we), 0);
        nxt(); @(negedge clk);
        chk("add_c3_rf_we", 32'(rf_we), 1);
        chk("add_c3_pc_we", 32'(pc_we), 1);
        chk("add_c3_pc_sel", 32'(pc_sel), 0);
        chk("add_c3_instret", instret, 0);
        $display("txn add: 4 cycles");

        // LOAD with three wait cycles in MEM
        nxt();
        set_ins(OP_LOAD, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("load_c0_instret", instret, 1);
        chk("load_c0_ir_we", 32'(ir_we), 1);
        nxt(); nxt();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt(); @(negedge clk);
            chk("load_wait_mem_req", 32'(mem_req), 1);
            chk("load_wait_addr_sel", 32'(addr_sel), 1);
            chk("load_wait_mem_we", 32'(mem_we), 0);
            chk("load_wait_pc_we", 32'(pc_we), 0);
        end
        nxt();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("load_c6_mem_req", 32'(mem_req), 1);
        chk("load_c6_rf_we", 32'(rf_we), 0);
        chk("load_c6_pc_we", 32'(pc_we), 0);
        nxt(); @(negedge clk);
        chk("load_c7_rf_we", 32'(rf_we), 1);
        chk("load_c7_pc_we", 32'(pc_we), 1);
        chk("load_c7_pc_sel", 32'(pc_sel), 0);
        chk("load_c7_trap", 32'(trap), 0);
        $display("txn load: 8 cycles");

        // BEQ taken
        nxt();
        set_ins(OP_BR, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("beq1_c0_instret", instret, 2);
        nxt(); nxt();
        branch_taken = 1'b1;
        @(negedge clk);
        chk("beq1_c2_pc_we", 32'(pc_we), 1);
        chk("beq1_c2_pc_sel", 32'(pc_sel), 1);
        chk("beq1_c2_rf_we", 32'(rf_we), 0);
        $display("txn beq taken: 3 cycles");

        // BEQ not taken
        nxt();
        branch_taken = 1'b0;
        @(negedge clk);
        chk("beq2_c0_instret", instret, 3);
        nxt(); nxt(); @(negedge clk);
        chk("beq2_c2_pc_we", 32'(pc_we), 1);
        chk("beq2_c2_pc_sel", 32'(pc_sel), 0);
        chk("beq2_c2_rf_we", 32'(rf_we), 0);
        $display("txn beq not taken: 3 cycles");

        // STORE, zero-wait
        nxt();
        set_ins(OP_STORE, 0, 1, 0, 0, 0, 0);
        nxt(); nxt(); @(negedge clk);
        chk("st_c2_mem_req", 32'(mem_req), 0);
        nxt(); @(negedge clk);
        chk("st_c3_mem_req", 32'(mem_req), 1);
        chk("st_c3_mem_we", 32'(mem_we), 1);
        chk("st_c3_addr_sel", 32'(addr_sel), 1);
        chk("st_c3_pc_we", 32'(pc_we), 1);
        chk("st_c3_pc_sel", 32'(pc_sel), 0);
        chk("st_c3_rf_we", 32'(rf_we), 0);
        chk("st_c3_instret", instret, 4);
        $display("txn store: 4 cycles");

        // JALR with halt requested at commit
        nxt();
        set_ins(OP_JALR, 0, 0, 1, 0, 0, 1);
        halt_req = 1'b1;
        @(negedge clk);
        chk("jalr_c0_instret", instret, 5);
        nxt(); @(negedge clk);
        chk("jalr_c1_halted", 32'(halted), 0);
        nxt(); nxt(); @(negedge clk);
        chk("jalr_c3_rf_we", 32'(rf_we), 1);
        chk("jalr_c3_pc_we", 32'(pc_we), 1);
        chk("jalr_c3_pc_sel", 32'(pc_sel), 3);
        nxt(); @(negedge clk);
        chk("halt_c4_halted", 32'(halted), 1);
        chk("halt_c4_mem_req", 32'(mem_req), 0);
        chk("halt_c4_instret", instret, 6);
        nxt();
        halt_req = 1'b0;
        @(negedge clk);
        chk("halt_c5_halted", 32'(halted), 1);
        chk("halt_c5_mem_req", 32'(mem_req), 0);
        nxt();
        set_ins(OP_BAD, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("resume_mem_req", 32'(mem_req), 1);
        chk("resume_halted", 32'(halted), 0);
        $display("txn jalr+halt: resumed");

        // Illegal opcode
        chk("ill_c0_ir_we", 32'(ir_we), 1);
        nxt(); @(negedge clk);
        chk("ill_c1_trap", 32'(trap), 0);
        nxt(); @(negedge clk);
        chk("ill_trap", 32'(trap), 1);
        chk("ill_cause", 32'(trap_cause), 1);
        chk("ill_mem_req", 32'(mem_req), 0);
        for (int i = 0; i < 20; i++) begin
            nxt(); @(negedge clk);
            chk("ill_idle_mem_req", 32'(mem_req | pc_we | ir_we), 0);
        end
        nxt();
        rst_n = 1'b0;
        #1;
        chk("ill_rst_trap", 32'(trap), 0);
        chk("ill_rst_mem_req", 32'(mem_req), 0);
        chk("ill_rst_instret", instret, 0);
        nxt();
        rst_n = 1'b1;
        $display("txn illegal opcode: trapped, reset");

        // Fetch timeout
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("ftmo_mem_req", 32'(mem_req), 1);
            chk("ftmo_trap_early", 32'(trap), 0);
            chk("ftmo_ir_we", 32'(ir_we), 0);
            nxt();
        end
        @(negedge clk);
        chk("ftmo_trap", 32'(trap), 1);
        chk("ftmo_cause", 32'(trap_cause), 2);
        chk("ftmo_mem_req_off", 32'(mem_req), 0);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("ftmo_rst_trap", 32'(trap), 0);
        chk("ftmo_rst_mem_req", 32'(mem_req), 0);
        nxt();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        set_ins(OP_STORE, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("ftmo_restart_mem_req", 32'(mem_req), 1);
        chk("ftmo_restart_trap", 32'(trap), 0);
        $display("txn fetch timeout: trapped, reset");

        // Data timeout on a store
        nxt(); nxt(); nxt();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("dtmo_mem_req", 32'(mem_req), 1);
            chk("dtmo_mem_we", 32'(mem_we), 1);
            chk("dtmo_pc_we", 32'(pc_we), 0);
            nxt();
        end
        @(negedge clk);
        chk("dtmo_trap", 32'(trap), 1);
        chk("dtmo_cause", 32'(trap_cause), 3);
        chk("dtmo_mem_req_off", 32'(mem_req), 0);
        $display("txn data timeout: trapped");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
